// File: rtl/psk_sweep_ctl_if.sv
// Bus between the PSK sweep sequencer and its NCO/correlator datapath.
// The master side drives start and the correlator values; the slave side
// (the sequencer) drives the NCO words, the correlator reset and the status.
interface psk_sweep_ctl_if #(
  parameter int CW_W  = 12,
  parameter int VAL_W = 8
);
  logic               start;
  logic [VAL_W-1:0]   i_value;
  logic [VAL_W-1:0]   q_value;
  logic [CW_W-1:0]    fcw;
  logic [CW_W-1:0]    pcw;
  logic               corr_rst;
  logic               busy;
  logic               done;
  logic               locked;
  logic [CW_W-1:0]    best_fcw;
  logic [CW_W-1:0]    best_pcw;
  logic [2*VAL_W:0]   best_energy;

  modport master (
    output start, i_value, q_value,
    input  fcw, pcw, corr_rst, busy, done, locked, best_fcw, best_pcw, best_energy
  );

  modport slave (
    input  start, i_value, q_value,
    output fcw, pcw, corr_rst, busy, done, locked, best_fcw, best_pcw, best_energy
  );
endinterface

// File: rtl/psk_sweep_ctl.sv
// PSK acquisition sequencer: walks the NCO frequency/phase grid, holds the
// correlators in reset while each setting settles, scores every grid point by
// I^2+Q^2 after a fixed dwell window and finally parks the NCOs on the best
// point, flagging lock when its energy reaches THRESH.
module psk_sweep_ctl #(
  parameter int                CW_W    = 12,
  parameter int                VAL_W   = 8,
  parameter int                WIN_LEN = 256,
  parameter int                SETTLE  = 4,
  parameter logic [CW_W-1:0]   F_START = 12'h0F0,
  parameter logic [CW_W-1:0]   F_STEP  = 12'h004,
  parameter int                F_COUNT = 8,
  parameter int                P_STEPS = 4,
  parameter int                THRESH  = 1000
) (
  input  logic              clk,
  input  logic              rst,
  psk_sweep_ctl_if.slave    bus
);

  localparam int E_W      = 2 * VAL_W + 1;
  localparam int CNT_MAX  = (WIN_LEN > SETTLE) ? WIN_LEN : SETTLE;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int P_W      = $clog2(P_STEPS) + 1;
  localparam int F_W      = $clog2(F_COUNT) + 1;
  localparam logic [CW_W-1:0] P_INC = CW_W'((2 ** CW_W) / P_STEPS);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_DWELL, S_DUMP, S_EVAL, S_NEXT, S_FIN
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [P_W-1:0]     pidx_q, pidx_d;
  logic [F_W-1:0]     fidx_q, fidx_d;
  logic [CW_W-1:0]    fcw_q, fcw_d;
  logic [CW_W-1:0]    pcw_q, pcw_d;
  logic [CW_W-1:0]    best_fcw_q, best_fcw_d;
  logic [CW_W-1:0]    best_pcw_q, best_pcw_d;
  logic [E_W-1:0]     best_energy_q, best_energy_d;
  logic               locked_q, locked_d;
  logic [VAL_W-1:0]   i_q, i_d;
  logic [VAL_W-1:0]   q_q, q_d;

  logic               settle_end;
  logic               dwell_end;
  logic               last_phase;
  logic               last_point;
  logic [E_W-1:0]     energy;

  assign settle_end = (cnt_q == CNT_W'(SETTLE - 1));
  assign dwell_end  = (cnt_q == CNT_W'(WIN_LEN - 1));
  assign last_phase = (pidx_q == P_W'(P_STEPS - 1));
  assign last_point = last_phase && (fidx_q == F_W'(F_COUNT - 1));
  // Full-width products: the sum of two max squares needs exactly E_W bits.
  assign energy     = E_W'(i_q) * E_W'(i_q) + E_W'(q_q) * E_W'(q_q);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      pidx_q        <= '0;
      fidx_q        <= '0;
      fcw_q         <= F_START;
      pcw_q         <= '0;
      best_fcw_q    <= '0;
      best_pcw_q    <= '0;
      best_energy_q <= '0;
      locked_q      <= 1'b0;
      i_q           <= '0;
      q_q           <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pidx_q        <= pidx_d;
      fidx_q        <= fidx_d;
      fcw_q         <= fcw_d;
      pcw_q         <= pcw_d;
      best_fcw_q    <= best_fcw_d;
      best_pcw_q    <= best_pcw_d;
      best_energy_q <= best_energy_d;
      locked_q      <= locked_d;
      i_q           <= i_d;
      q_q           <= q_d;
    end
  end

  // Next-state decode for the sweep sequence.
  always_comb begin
    // NOTE: a default assignment first keeps every path assigned, so no
    // latch is inferred when a branch leaves the value untouched.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (bus.start) state_d = S_SETTLE;
      S_SETTLE: if (settle_end) state_d = S_DWELL;
      S_DWELL:  if (dwell_end)  state_d = S_DUMP;
      S_DUMP:   state_d = S_EVAL;
      S_EVAL:   state_d = S_NEXT;
      S_NEXT:   state_d = last_point ? S_FIN : S_SETTLE;
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Counters, grid stepping, correlator capture and best-point tracking.
  always_comb begin
    cnt_d         = '0;
    pidx_d        = pidx_q;
    fidx_d        = fidx_q;
    fcw_d         = fcw_q;
    pcw_d         = pcw_q;
    best_fcw_d    = best_fcw_q;
    best_pcw_d    = best_pcw_q;
    best_energy_d = best_energy_q;
    locked_d      = locked_q;
    i_d           = i_q;
    q_d           = q_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          fcw_d         = F_START;
          pcw_d         = '0;
          pidx_d        = '0;
          fidx_d        = '0;
          // Seeding the best point with the first grid point makes an
          // all-zero sweep report that point under the strict compare.
          best_fcw_d    = F_START;
          best_pcw_d    = '0;
          best_energy_d = '0;
          locked_d      = 1'b0;
        end
      end
      S_SETTLE: cnt_d = settle_end ? '0 : cnt_q + 1'b1;
      S_DWELL:  cnt_d = dwell_end  ? '0 : cnt_q + 1'b1;
      S_DUMP: begin
        i_d = bus.i_value;
        q_d = bus.q_value;
      end
      S_EVAL: begin
        if (energy > best_energy_q) begin
          best_energy_d = energy;
          best_fcw_d    = fcw_q;
          best_pcw_d    = pcw_q;
        end
      end
      S_NEXT: begin
        if (last_point) begin
          // Park on the winner so the words are already valid during FIN.
          fcw_d    = best_fcw_q;
          pcw_d    = best_pcw_q;
          locked_d = (best_energy_q >= E_W'(THRESH));
        end else if (last_phase) begin
          pidx_d = '0;
          pcw_d  = '0;
          fcw_d  = fcw_q + F_STEP;
          fidx_d = fidx_q + 1'b1;
        end else begin
          pidx_d = pidx_q + 1'b1;
          pcw_d  = pcw_q + P_INC;
        end
      end
      default: ;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    bus.corr_rst    = (state_q != S_DWELL);
    bus.busy        = (state_q != S_IDLE) && (state_q != S_FIN);
    bus.done        = (state_q == S_FIN);
    bus.fcw         = fcw_q;
    bus.pcw         = pcw_q;
    bus.locked      = locked_q;
    bus.best_fcw    = best_fcw_q;
    bus.best_pcw    = best_pcw_q;
    bus.best_energy = best_energy_q;
  end

endmodule

// File: tb/tb_psk_sweep_ctl.sv
// Bench for psk_sweep_ctl: two instances (nominal and wrapping F_START),
// scoreboard of expected dwell grid points, final best-point checks.
module tb_psk_sweep_ctl;
  localparam int CW   = 12;
  localparam int VAL  = 8;
  localparam int WIN  = 8;
  localparam int SET  = 2;
  localparam int FC   = 3;
  localparam int PS   = 4;
  localparam int SWEEP_CYC = FC * PS * (SET + WIN + 3) + 1;

  typedef struct packed {
    logic [CW-1:0] f;
    logic [CW-1:0] p;
  } point_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic start = 1'b0;
  logic [VAL-1:0] i_val = '0;
  logic [VAL-1:0] q_val = '0;

  int n_vec = 0;
  int n_err = 0;
  point_t exp_q[$];

  always #5 clk = ~clk;

  psk_sweep_ctl_if #(.CW_W(CW), .VAL_W(VAL)) a_if ();
  psk_sweep_ctl_if #(.CW_W(CW), .VAL_W(VAL)) w_if ();

  assign a_if.start   = start & ~sel;
  assign w_if.start   = start & sel;
  assign a_if.i_value = i_val;
  assign a_if.q_value = q_val;
  assign w_if.i_value = i_val;
  assign w_if.q_value = q_val;

  psk_sweep_ctl #(.CW_W(CW), .VAL_W(VAL), .WIN_LEN(WIN), .SETTLE(SET),
    .F_START(12'h0F0), .F_STEP(12'h004), .F_COUNT(FC), .P_STEPS(PS),
    .THRESH(1000)) dut_a (.clk(clk), .rst(rst), .bus(a_if));

  psk_sweep_ctl #(.CW_W(CW), .VAL_W(VAL), .WIN_LEN(WIN), .SETTLE(SET),
    .F_START(12'hFFC), .F_STEP(12'h004), .F_COUNT(FC), .P_STEPS(PS),
    .THRESH(1000)) dut_w (.clk(clk), .rst(rst), .bus(w_if));

  logic [CW-1:0]  o_fcw, o_pcw, o_bf, o_bp;
  logic [2*VAL:0] o_be;
  logic           o_crst, o_busy, o_done, o_lock;
  assign o_fcw  = sel ? w_if.fcw         : a_if.fcw;
  assign o_pcw  = sel ? w_if.pcw         : a_if.pcw;
  assign o_bf   = sel ? w_if.best_fcw    : a_if.best_fcw;
  assign o_bp   = sel ? w_if.best_pcw    : a_if.best_pcw;
  assign o_be   = sel ? w_if.best_energy : a_if.best_energy;
  assign o_crst = sel ? w_if.corr_rst    : a_if.corr_rst;
  assign o_busy = sel ? w_if.busy        : a_if.busy;
  assign o_done = sel ? w_if.done        : a_if.done;
  assign o_lock = sel ? w_if.locked      : a_if.locked;

  // Correlator stimulus as a function of the grid point: {i, q}.
  function automatic logic [15:0] pat(input int p, input logic [CW-1:0] f,
                                      input logic [CW-1:0] ph);
    case (p)
      0:       return (f == 12'h0F4 && ph == 12'h800) ? 16'h4030 : 16'h0505;
      1:       return 16'h0000;
      default: return 16'hFFFF;
    endcase
  endfunction

  // Starts a sweep, scoreboards every dwell point and returns the cycle of
  // done (cycle 1 = the cycle after the start-accept edge) and the model's
  // expected best point. Returns while the DUT is still in the done cycle.
  task automatic run_sweep(input int p, input logic [CW-1:0] f0,
                           output int done_cyc, output logic [2*VAL:0] e_be,
                           output logic [CW-1:0] e_bf, output logic [CW-1:0] e_bp);
    logic [CW-1:0] f, ph;
    logic [15:0]   iq;
    int            e;
    int            best;
    logic          prev_crst;
    logic          got_done;
    point_t        pt;
    best = 0;
    e_bf = f0;
    e_bp = '0;
    exp_q.delete();
    for (int fi = 0; fi < FC; fi++) begin
      for (int pi = 0; pi < PS; pi++) begin
        f  = f0 + CW'(fi * 4);
        ph = CW'(pi * 12'h400);
        exp_q.push_back('{f: f, p: ph});
        iq = pat(p, f, ph);
        e  = int'(iq[15:8]) * int'(iq[15:8]) + int'(iq[7:0]) * int'(iq[7:0]);
        if (e > best) begin
          best = e;
          e_bf = f;
          e_bp = ph;
        end
      end
    end
    e_be = (2*VAL+1)'(best);

    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_cyc  = 0;
    got_done  = 1'b0;
    prev_crst = 1'b1;
    while (!got_done && done_cyc < 2 * SWEEP_CYC) begin
      @(negedge clk);
      done_cyc++;
      iq = pat(p, o_fcw, o_pcw);
      i_val = iq[15:8];
      q_val = iq[7:0];
      if (done_cyc == 1) begin
        n_vec++;
        if (o_busy !== 1'b1) begin
          n_err++;
          $display("FAIL busy_after_start: got %b want 1", o_busy);
        end
      end
      if (prev_crst && !o_crst) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL dwell_extra: unexpected dwell at fcw=%h pcw=%h", o_fcw, o_pcw);
        end else begin
          pt = exp_q.pop_front();
          if (o_fcw !== pt.f || o_pcw !== pt.p) begin
            n_err++;
            $display("FAIL dwell_point: got fcw=%h pcw=%h want fcw=%h pcw=%h",
                     o_fcw, o_pcw, pt.f, pt.p);
          end
        end
      end
      prev_crst = o_crst;
      if (o_done) got_done = 1'b1;
    end
    n_vec++;
    if (!got_done || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sweep_end: done=%b leftover_points=%0d want done=1 leftover=0",
               got_done, exp_q.size());
    end
  endtask

  // Final-result checks in the done cycle, then done must drop and the
  // parked words must hold in IDLE.
  task automatic check_result(input string nm, input int cyc, input logic [2*VAL:0] e_be,
                              input logic [CW-1:0] e_bf, input logic [CW-1:0] e_bp,
                              input logic e_lock);
    n_vec++;
    if (cyc !== SWEEP_CYC) begin
      n_err++;
      $display("FAIL %s_done_cycle: got %0d want %0d", nm, cyc, SWEEP_CYC);
    end
    n_vec++;
    if (o_bf !== e_bf || o_bp !== e_bp || o_be !== e_be) begin
      n_err++;
      $display("FAIL %s_best: got f=%h p=%h e=%0d want f=%h p=%h e=%0d",
               nm, o_bf, o_bp, o_be, e_bf, e_bp, e_be);
    end
    n_vec++;
    if (o_lock !== e_lock || o_busy !== 1'b0 || o_crst !== 1'b1) begin
      n_err++;
      $display("FAIL %s_fin_flags: got lock=%b busy=%b crst=%b want lock=%b busy=0 crst=1",
               nm, o_lock, o_busy, o_crst, e_lock);
    end
    n_vec++;
    if (o_fcw !== e_bf || o_pcw !== e_bp) begin
      n_err++;
      $display("FAIL %s_parked: got fcw=%h pcw=%h want fcw=%h pcw=%h",
               nm, o_fcw, o_pcw, e_bf, e_bp);
    end
    @(negedge clk);
    n_vec++;
    if (o_done !== 1'b0 || o_fcw !== e_bf || o_lock !== e_lock) begin
      n_err++;
      $display("FAIL %s_after_done: got done=%b fcw=%h lock=%b want done=0 fcw=%h lock=%b",
               nm, o_done, o_fcw, o_lock, e_bf, e_lock);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (o_fcw !== 12'h0F0 || o_pcw !== 12'h000 || o_crst !== 1'b1) begin
      n_err++;
      $display("FAIL reset_words: got fcw=%h pcw=%h crst=%b want 0f0 000 1", o_fcw, o_pcw, o_crst);
    end
    n_vec++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_lock !== 1'b0 ||
        o_bf !== '0 || o_bp !== '0 || o_be !== '0) begin
      n_err++;
      $display("FAIL reset_status: got busy=%b done=%b lock=%b bf=%h bp=%h be=%0d want all 0",
               o_busy, o_done, o_lock, o_bf, o_bp, o_be);
    end
    rst = 1'b0;
  endtask

  task automatic test_peak_find();
    int cyc;
    logic [2*VAL:0] e_be;
    logic [CW-1:0] e_bf, e_bp;
    sel = 1'b0;
    run_sweep(0, 12'h0F0, cyc, e_be, e_bf, e_bp);
    check_result("peak", cyc, 17'd6400, 12'h0F4, 12'h800, 1'b1);
    n_vec++;
    if (e_be !== 17'd6400 || e_bf !== 12'h0F4 || e_bp !== 12'h800) begin
      n_err++;
      $display("FAIL peak_model: got model e=%0d f=%h p=%h want 6400 0f4 800", e_be, e_bf, e_bp);
    end
  endtask

  task automatic test_all_zero();
    int cyc;
    logic [2*VAL:0] e_be;
    logic [CW-1:0] e_bf, e_bp;
    sel = 1'b0;
    run_sweep(1, 12'h0F0, cyc, e_be, e_bf, e_bp);
    check_result("zero", cyc, 17'd0, 12'h0F0, 12'h000, 1'b0);
  endtask

  task automatic test_wrap();
    int cyc;
    logic [2*VAL:0] e_be;
    logic [CW-1:0] e_bf, e_bp;
    sel = 1'b1;
    run_sweep(0, 12'hFFC, cyc, e_be, e_bf, e_bp);
    check_result("wrap", cyc, 17'd50, 12'hFFC, 12'h000, 1'b0);
    sel = 1'b0;
  endtask

  task automatic test_full_scale();
    int cyc;
    logic [2*VAL:0] e_be;
    logic [CW-1:0] e_bf, e_bp;
    sel = 1'b0;
    run_sweep(2, 12'h0F0, cyc, e_be, e_bf, e_bp);
    check_result("full", cyc, 17'h1FC02, 12'h0F0, 12'h000, 1'b1);
  endtask

  task automatic test_abort();
    int cyc;
    logic [2*VAL:0] e_be;
    logic [CW-1:0] e_bf, e_bp;
    sel = 1'b0;
    i_val = 8'h05;
    q_val = 8'h05;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    // Cycles 3..10 are the first dwell window.
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    n_vec++;
    if (o_crst !== 1'b0 || o_busy !== 1'b1) begin
      n_err++;
      $display("FAIL abort_start_ignored: got crst=%b busy=%b want 0 1", o_crst, o_busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if (o_crst !== 1'b1 || o_busy !== 1'b0 || o_fcw !== 12'h0F0 || o_pcw !== 12'h000) begin
      n_err++;
      $display("FAIL abort_rst: got crst=%b busy=%b fcw=%h pcw=%h want 1 0 0f0 000",
               o_crst, o_busy, o_fcw, o_pcw);
    end
    run_sweep(0, 12'h0F0, cyc, e_be, e_bf, e_bp);
    check_result("restart", cyc, 17'd6400, 12'h0F4, 12'h800, 1'b1);
  endtask

  initial begin
    test_reset();
    test_peak_find();
    test_all_zero();
    test_wrap();
    test_full_scale();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
